// File: rtl/prog_loader.sv
// Program-image loader: streams bytes into consecutive RAM addresses, then pulses done/run.
// Define PROG_LOADER_VERIFY_EN to add a read-back checksum pass that drives err.
module prog_loader #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    output logic          ram_rden,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          done,
    output logic          run,
    output logic          err,
    output logic [DW-1:0] csum
);

    typedef enum logic [2:0] {StIdle, StLoad, StVrd, StVcmp, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] csum_q, csum_d;
    logic          accept;
    logic          last;

    assign accept = (state_q == StLoad) && in_valid;
    // len of zero wraps to all-ones here, so a zero length covers the full 2**AW bytes.
    assign last   = (cnt_q == len_q - AW'(1));

`ifdef PROG_LOADER_VERIFY_EN
    logic [DW-1:0] vsum_q, vsum_d;
    logic          rd_pend_q, rd_pend_d;
    logic          err_q, err_d;
`else
    logic unused_ram_q;
    assign unused_ram_q = ^ram_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            vsum_q    <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
`ifdef PROG_LOADER_VERIFY_EN
            vsum_q    <= vsum_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
`ifdef PROG_LOADER_VERIFY_EN
        err_d     = err_q;
        rd_pend_d = (state_q == StVrd);
        // Read data arrives the cycle after each read request.
        vsum_d    = rd_pend_q ? vsum_q + ram_q : vsum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    base_d  = base;
                    len_d   = len;
                    cnt_d   = '0;
                    csum_d  = '0;
`ifdef PROG_LOADER_VERIFY_EN
                    err_d   = 1'b0;
                    vsum_d  = '0;
`endif
                end
            end
            StLoad: begin
                if (accept) begin
                    cnt_d  = cnt_q + AW'(1);
                    csum_d = csum_q + in_data;
                    if (last) begin
                        cnt_d = '0;
`ifdef PROG_LOADER_VERIFY_EN
                        state_d = StVrd;
`else
                        state_d = StDone;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_VERIFY_EN
            StVrd: begin
                cnt_d = cnt_q + AW'(1);
                if (last) begin
                    state_d = StVcmp;
                end
            end
            StVcmp: begin
                err_d   = ((vsum_q + ram_q) != csum_q);
                state_d = StDone;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        in_ready = (state_q == StLoad);
        ram_wren = accept;
        ram_rden = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        if (accept) begin
            ram_addr = base_q + cnt_q;
            ram_data = in_data;
        end
`ifdef PROG_LOADER_VERIFY_EN
        if (state_q == StVrd) begin
            ram_rden = 1'b1;
            ram_addr = base_q + cnt_q;
        end
        err = err_q;
`else
        err = 1'b0;
`endif
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        run  = done && !err;
        csum = csum_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of load vectors plus abort, full-length,
// verify and mid-load reset sequences against a behavioural byte RAM.
module tb_prog_loader;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic          ram_rden;
    logic [DW-1:0] ram_q = '0;
    logic          busy;
    logic          done;
    logic          run;
    logic          err;
    logic [DW-1:0] csum;

    always #5 clk = ~clk;

    prog_loader #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .abort    (abort),
        .base     (base),
        .len      (len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_rden (ram_rden),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done),
        .run      (run),
        .err      (err),
        .csum     (csum)
    );

    // Byte RAM: read data for a request seen at one negedge appears at the next negedge.
    logic [7:0] mem [256];
    logic       rd_s = 1'b0;
    logic [7:0] rda_s = '0;
    logic       corrupt = 1'b0;
    int         done_cnt = 0;
    int         run_cnt = 0;
    int         wr_cnt = 0;

    always @(negedge clk) begin
        if (rd_s) ram_q = (corrupt && rda_s == 8'h02) ? ~mem[rda_s] : mem[rda_s];
        rd_s  = ram_rden;
        rda_s = ram_addr;
        if (ram_wren) begin
            mem[ram_addr] = ram_data;
            wr_cnt++;
        end
        if (done) done_cnt++;
        if (run) run_cnt++;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] outs();
        return {in_ready, ram_wren, ram_rden, busy, done, run, err, ram_addr, ram_data, csum};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) check("in_ready wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 600) begin
            tick();
            cycles++;
        end
    endtask

    typedef struct {
        logic [7:0]       base;
        logic [7:0]       len;
        int               n;
        logic [3:0][7:0]  d;
        logic [3:0]       gap;
        logic [3:0][7:0]  addr;
        logic [7:0]       csum;
    } vec_t;

    vec_t vt [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, r0, w0, lat, exp_lat;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // d/addr listed high-to-low: element 0 is the first byte sent.
        vt[0] = '{base: 8'h00, len: 8'h04, n: 4, d: {8'h44, 8'h33, 8'h22, 8'h11},
                  gap: 4'b0000, addr: {8'h03, 8'h02, 8'h01, 8'h00}, csum: 8'hAA};
        vt[1] = '{base: 8'hFE, len: 8'h03, n: 3, d: {8'h00, 8'h03, 8'h02, 8'h01},
                  gap: 4'b0111, addr: {8'h00, 8'h00, 8'hFF, 8'hFE}, csum: 8'h06};
        vt[2] = '{base: 8'h80, len: 8'h02, n: 2, d: {8'h00, 8'h00, 8'h02, 8'hFF},
                  gap: 4'b0010, addr: {8'h00, 8'h00, 8'h81, 8'h80}, csum: 8'h01};
        vt[3] = '{base: 8'h10, len: 8'h01, n: 1, d: {8'h00, 8'h00, 8'h00, 8'h5A},
                  gap: 4'b0000, addr: {8'h00, 8'h00, 8'h00, 8'h10}, csum: 8'h5A};

        // Reset state
        #12;
        check("reset outputs", 32'(outs()), 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("idle after reset", 32'(outs()), 0);

        // Abort after two of five bytes
        d0 = done_cnt; r0 = run_cnt;
        do_start(8'h40, 8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 0);
        repeat (3) tick();
        check("abort done count", done_cnt - d0, 0);
        check("abort run count", run_cnt - r0, 0);
        check("abort ram[40]", mem[8'h40], 8'h11);
        check("abort ram[41]", mem[8'h41], 8'h22);
        check("abort ram[42]", mem[8'h42], 8'h00);

        // Table of normal loads
`ifdef PROG_LOADER_VERIFY_EN
        exp_lat = 1;
`else
        exp_lat = 0;
`endif
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt; r0 = run_cnt; w0 = wr_cnt;
            do_start(vt[v].base, vt[v].len);
            check($sformatf("v%0d csum cleared", v), csum, 0);
            check($sformatf("v%0d busy", v), busy, 1);
            for (int i = 0; i < vt[v].n; i++) begin
                if (vt[v].gap[i]) begin
                    in_valid = 1'b0;
                    #1;
                    check($sformatf("v%0d gap ready/wren", v), {in_ready, ram_wren}, 2'b10);
                    tick();
                end
                send_byte(vt[v].d[i]);
            end
            wait_done(lat);
`ifdef PROG_LOADER_VERIFY_EN
            check($sformatf("v%0d done latency", v), lat, vt[v].len + exp_lat);
`else
            check($sformatf("v%0d done latency", v), lat, exp_lat);
`endif
            check($sformatf("v%0d run with done", v), {done, run, err}, 3'b110);
            tick();
            check($sformatf("v%0d idle after", v), {busy, done, run}, 3'b000);
            check($sformatf("v%0d csum", v), csum, vt[v].csum);
            check($sformatf("v%0d done count", v), done_cnt - d0, 1);
            check($sformatf("v%0d run count", v), run_cnt - r0, 1);
            check($sformatf("v%0d write count", v), wr_cnt - w0, vt[v].n);
            for (int i = 0; i < vt[v].n; i++)
                check($sformatf("v%0d ram[%0h]", v, vt[v].addr[i]), mem[vt[v].addr[i]],
                      vt[v].d[i]);
        end

        // len=0 loads 256 bytes; start during LOAD is ignored
        d0 = done_cnt; w0 = wr_cnt;
        do_start(8'h00, 8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        base  = 8'h55;
        len   = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("full start ignored csum", csum, 8'h2D);
        for (int i = 10; i < 255; i++) send_byte(8'(i));
        check("full 255 still loading", {busy, in_ready, done}, 3'b110);
        send_byte(8'hFF);
        wait_done(lat);
        check("full done", done, 1);
        tick();
        check("full csum", csum, 8'h80);
        check("full done count", done_cnt - d0, 1);
        check("full write count", wr_cnt - w0, 256);
        check("full ram[0a]", mem[8'h0A], 8'h0A);
        check("full ram[ab]", mem[8'hAB], 8'hAB);
        check("full ram[ff]", mem[8'hFF], 8'hFF);

`ifdef PROG_LOADER_VERIFY_EN
        // Corrupted read-back at address 2, then a clean pass
        for (int pass = 0; pass < 2; pass++) begin
            corrupt = (pass == 0);
            d0 = done_cnt; r0 = run_cnt;
            do_start(8'h00, 8'h04);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h03);
            send_byte(8'h04);
            wait_done(lat);
            check($sformatf("verify%0d latency", pass), lat, 5);
            check($sformatf("verify%0d done/run/err", pass), {done, run, err},
                  (pass == 0) ? 3'b101 : 3'b110);
            tick();
            check($sformatf("verify%0d err held", pass), err, (pass == 0) ? 1 : 0);
            check($sformatf("verify%0d run count", pass), run_cnt - r0, pass);
            check($sformatf("verify%0d done count", pass), done_cnt - d0, 1);
        end
        corrupt = 1'b0;
`endif

        // Reset in the middle of a load
        d0 = done_cnt; r0 = run_cnt; w0 = wr_cnt;
        do_start(8'h60, 8'h04);
        send_byte(8'hA1);
        send_byte(8'hA2);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        rstn = 1'b0;
        #1;
        check("rst low outputs", 32'(outs()), 0);
        tick();
        tick();
        check("rst held outputs", 32'(outs()), 0);
        rstn = 1'b1;
        repeat (4) tick();
        check("rst release idle", {busy, in_ready, ram_wren}, 3'b000);
        in_valid = 1'b0;
        check("rst done count", done_cnt - d0, 0);
        check("rst run count", run_cnt - r0, 0);
        check("rst write count", wr_cnt - w0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
